// File: rtl/aska_spi_pkg.sv
// Shared encodings for the ASKA SPI configuration port.
package aska_spi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_FULL,
    ST_OVER
  } spi_state_e;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int ERR_CNT_W    = 8;
endpackage

// File: rtl/aska_spi_sync.sv
// Synchronises the SPI pins into clk and produces registered edge pulses
// for SPI_Clk and SPI_CS, detected on the last two synchroniser taps.
module aska_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic cs_pin,
  input  logic sclk_pin,
  input  logic mosi_pin,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);
  logic [SYNC_STAGES-1:0] cs_t, sclk_t, mosi_t;

  // CS taps reset low so a CS still held low across reset does not look
  // like a fresh falling edge; a later rise is harmless in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_t      <= '0;
      sclk_t    <= '0;
      mosi_t    <= '0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
    end else begin
      cs_t      <= {cs_t[SYNC_STAGES-2:0], cs_pin};
      sclk_t    <= {sclk_t[SYNC_STAGES-2:0], sclk_pin};
      mosi_t    <= {mosi_t[SYNC_STAGES-2:0], mosi_pin};
      sclk_rise <= sclk_t[SYNC_STAGES-2] & ~sclk_t[SYNC_STAGES-1];
      sclk_fall <= ~sclk_t[SYNC_STAGES-2] & sclk_t[SYNC_STAGES-1];
      cs_rise   <= cs_t[SYNC_STAGES-2] & ~cs_t[SYNC_STAGES-1];
      cs_fall   <= ~cs_t[SYNC_STAGES-2] & cs_t[SYNC_STAGES-1];
    end
  end

  assign mosi = mosi_t[SYNC_STAGES-1];
endmodule

// File: rtl/aska_spi_regbank.sv
// SPI mode-0 slave register bank: command byte + DATA_BYTES payload,
// validated at CS rise before anything is committed.
module aska_spi_regbank
  import aska_spi_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_BYTES*8-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             SPI_CS,
  input  logic                             SPI_Clk,
  input  logic                             SPI_MOSI,
  output logic                             SPI_MISO,
  output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]              wr_strobe,
  output logic                             rd_done,
  output logic                             frame_err,
  output logic [ERR_CNT_W-1:0]             err_count
);
  localparam int W          = DATA_BYTES * 8;
  localparam int FRAME_BITS = 8 + W;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  logic mosi, sclk_rise, sclk_fall, cs_rise, cs_fall;

  aska_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .cs_pin   (SPI_CS),
    .sclk_pin (SPI_Clk),
    .mosi_pin (SPI_MOSI),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  spi_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    cmd_sr;
  logic [7:0]    cmd_q, cmd_nxt;
  logic [W-1:0]  stage, tx, rd_word;
  logic [NUM_REGS-1:0][W-1:0] regs;
  logic miso_q;
  logic eval, in_range, ok_full, ignore, do_wr, do_rd, do_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A CS fall outside IDLE closes the old frame and opens a new one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      eval    = (state_q != ST_IDLE);
    end else if (cs_fall) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      eval    = (state_q != ST_IDLE);
    end else if (sclk_rise && state_q != ST_IDLE) begin
      if (cnt_q != CW'(FRAME_BITS)) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_CMD:  if (cnt_q == CW'(7)) state_d = ST_DATA;
        ST_DATA: if (cnt_q == CW'(FRAME_BITS - 1)) state_d = ST_FULL;
        ST_FULL: state_d = ST_OVER;
        default: ;
      endcase
    end
  end

  assign in_range = ({1'b0, cmd_q[CMD_ADDR_MSB:0]} < 8'(NUM_REGS));
  assign ok_full  = (state_q == ST_FULL) && in_range;
  assign ignore   = (state_q == ST_CMD) && (cnt_q == '0);
  assign do_wr    = eval && ok_full && !cmd_q[CMD_RW_BIT];
  assign do_rd    = eval && ok_full && cmd_q[CMD_RW_BIT];
  assign do_err   = eval && !ok_full && !ignore;
  assign cmd_nxt  = {cmd_sr, mosi};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_nxt[CMD_ADDR_MSB:0] == 7'(i)) rd_word = regs[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_sr    <= '0;
      cmd_q     <= '0;
      stage     <= '0;
      tx        <= '0;
      miso_q    <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      rd_done   <= do_rd;
      frame_err <= do_err;
      if (do_err && err_count != '1) err_count <= err_count + 1'b1;
      if (sclk_rise && state_q == ST_CMD) begin
        cmd_sr <= cmd_nxt[6:0];
        if (cnt_q == CW'(7)) begin
          cmd_q <= cmd_nxt;
          tx    <= rd_word;
        end
      end
      if (sclk_rise && state_q == ST_DATA) stage <= {stage[W-2:0], mosi};
      // MISO only carries data during the payload phase of a read.
      if (state_q == ST_DATA && cmd_q[CMD_RW_BIT]) begin
        if (sclk_fall) begin
          miso_q <= tx[W-1];
          tx     <= tx << 1;
        end
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs      <= {NUM_REGS{RESET_VAL}};
      wr_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_strobe[i] <= do_wr && (cmd_q[CMD_ADDR_MSB:0] == 7'(i));
        if (do_wr && (cmd_q[CMD_ADDR_MSB:0] == 7'(i))) regs[i] <= stage;
      end
    end
  end

  assign reg_out  = regs;
  assign SPI_MISO = miso_q;
endmodule
